// File: rtl/font_pkg.sv
// Shared widths, digit limit and lookup FSM encoding for the numeric font ROM arbiter.
package font_pkg;

   localparam int DEF_DIGIT_W = 4;
   localparam int DEF_ROW_W   = 4;
   localparam int DEF_DATA_W  = 16;

   // Highest glyph index backed by the numeric font; larger indices report an error.
   localparam int unsigned MAX_DIGIT = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       enable,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one combinational font ROM between two requesters: accept, one-cycle lookup, held response.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid holds until then.
module font_rom_arbiter
   import font_pkg::*;
#(
   parameter int DIGIT_W = DEF_DIGIT_W,
   parameter int ROW_W   = DEF_ROW_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_valid,
   input  logic [DIGIT_W-1:0]       req0_digit,
   input  logic [ROW_W-1:0]         req0_row,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic [DIGIT_W-1:0]       req1_digit,
   input  logic [ROW_W-1:0]         req1_row,
   output logic                     req1_ready,
   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic [DATA_W-1:0]        rsp0_data,
   output logic                     rsp0_err,
   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [DATA_W-1:0]        rsp1_data,
   output logic                     rsp1_err,
   output logic [DIGIT_W+ROW_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [1:0]               dbg_state
);

   localparam int ADDR_W = DIGIT_W + ROW_W;

   state_t             state;
   logic               owner;
   logic               last_grant;
   logic [1:0]         grant;
   logic [1:0]         valid_q;
   logic [DATA_W-1:0]  data_q;
   logic               err_q;
   logic               digit_bad;
   logic               owner_ready;

   rr_arbiter2 u_arb (
      .valid  ({req1_valid, req0_valid}),
      .enable (state == ST_IDLE),
      .last   (last_grant),
      .grant  (grant)
   );

   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;

   // The captured digit lives in the upper field of rom_addr during LOOKUP.
   assign digit_bad = 32'(rom_addr[ADDR_W-1:ROW_W]) > MAX_DIGIT;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         rom_addr   <= '0;
         valid_q    <= 2'b00;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  state      <= ST_LOOKUP;
                  owner      <= grant[1];
                  last_grant <= grant[1];
                  rom_addr   <= grant[1] ? {req1_digit, req1_row} : {req0_digit, req0_row};
               end
            end
            ST_LOOKUP: begin
               state    <= ST_RESP;
               rom_addr <= '0;
               valid_q  <= owner ? 2'b10 : 2'b01;
               data_q   <= digit_bad ? '0 : rom_data;
               err_q    <= digit_bad;
            end
            ST_RESP: begin
               if (owner_ready) begin
                  state   <= ST_IDLE;
                  valid_q <= 2'b00;
                  data_q  <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rsp0_valid = valid_q[0];
   assign rsp1_valid = valid_q[1];
   assign rsp0_data  = valid_q[0] ? data_q : '0;
   assign rsp1_data  = valid_q[1] ? data_q : '0;
   assign rsp0_err   = valid_q[0] & err_q;
   assign rsp1_err   = valid_q[1] & err_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Randomized bench for font_rom_arbiter with a transaction-level round-robin model and response scoreboard.
module tb_font_rom_arbiter;
   import font_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_digit, req0_row, req1_digit, req1_row;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [15:0] rsp0_data, rsp1_data;
   logic        rsp0_err, rsp1_err;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [1:0]  dbg_state;

   int tests = 0;
   int fails = 0;
   int m_last = 1;               // model: id granted last, 1 after reset
   logic [17:0] exp_q[$];        // {owner, err, data}
   logic [17:0] mon_e;

   always #5 clk = ~clk;

   font_rom_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_digit(req0_digit), .req0_row(req0_row), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_digit(req1_digit), .req1_row(req1_row), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
   );

   function automatic logic [15:0] rom_fn(input logic [7:0] a);
      if (a == 8'h35) return 16'hA5C3;
      return {a, ~a} ^ 16'h1234;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples shortly after each falling edge, once the drivers have settled.
   always begin
      @(negedge clk);
      #2;
      if (!reset && (rsp0_valid || rsp1_valid)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
         end else begin
            mon_e = exp_q[0];
            check("rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, mon_e[17] ? 32'd2 : 32'd1);
            check("req_ready_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
            if (mon_e[17]) begin
               check("rsp1_data", {16'd0, rsp1_data}, {16'd0, mon_e[15:0]});
               check("rsp1_err", {31'd0, rsp1_err}, {31'd0, mon_e[16]});
               check("rsp0_quiet", {15'd0, rsp0_err, rsp0_data}, 32'd0);
               if (rsp1_ready) void'(exp_q.pop_front());
            end else begin
               check("rsp0_data", {16'd0, rsp0_data}, {16'd0, mon_e[15:0]});
               check("rsp0_err", {31'd0, rsp0_err}, {31'd0, mon_e[16]});
               check("rsp1_quiet", {15'd0, rsp1_err, rsp1_data}, 32'd0);
               if (rsp0_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // One arbitration round; the loser keeps its request up to prove it is ignored while busy.
   task automatic do_round(input logic v0, input logic v1, input logic [3:0] d0, input logic [3:0] r0,
                           input logic [3:0] d1, input logic [3:0] r1, input int stall);
      int w;
      logic [3:0] d, r;
      logic [7:0] a;
      @(negedge clk);
      w = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
      m_last = w;
      d = (w == 1) ? d1 : d0;
      r = (w == 1) ? r1 : r0;
      a = {d, r};
      exp_q.push_back({w[0], d > 4'd9, (d > 4'd9) ? 16'h0000 : rom_fn(a)});
      rsp0_ready = !(w == 0 && stall > 0);
      rsp1_ready = !(w == 1 && stall > 0);
      req0_valid = v0; req0_digit = d0; req0_row = r0;
      req1_valid = v1; req1_digit = d1; req1_row = r1;
      #1;
      check("req_grant", {30'd0, req1_ready, req0_ready}, (w == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
      check("rom_addr_lookup", {24'd0, rom_addr}, {24'd0, a});
      check("rsp_early", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check("req_ready_lookup", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
      @(negedge clk);
      check("rsp_latency", {30'd0, rsp1_valid, rsp0_valid}, (w == 1) ? 32'd2 : 32'd1);
      check("rom_addr_resp", {24'd0, rom_addr}, 32'd0);
      repeat (stall) @(negedge clk);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      @(negedge clk);
      check("idle_after_hs", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("rsp_dropped", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_digit = 0; req0_row = 0; req1_digit = 0; req1_row = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      #12;
      check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("reset_addr", {24'd0, rom_addr}, 32'd0);
      check("reset_rsp", {28'd0, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      do_round(1, 0, 4'd3, 4'd5, 4'd0, 4'd0, 0);                 // A5C3 lookup
      for (int i = 0; i < 4; i++) do_round(1, 1, 4'd1, 4'(i), 4'd7, 4'(i), 0);
      do_round(0, 1, 4'd0, 4'd0, 4'd12, 4'd0, 0);                // out-of-range digit
      do_round(1, 1, 4'd8, 4'd15, 4'd2, 4'd2, 5);                // backpressure on req0

      // Reset in the middle of a lookup.
      @(negedge clk);
      req0_valid = 1; req0_digit = 4'd5; req0_row = 4'd2;
      @(negedge clk);
      check("rst_lookup_addr", {24'd0, rom_addr}, 32'h52);
      req0_valid = 0;
      reset = 1'b1;
      #1;
      check("rst_async_addr", {24'd0, rom_addr}, 32'd0);
      check("rst_async_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("rst_async_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      m_last = 1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      do_round(1, 1, 4'd9, 4'd1, 4'd4, 4'd4, 0);

      for (int i = 0; i < 40; i++) begin
         int vp;
         vp = $urandom_range(1, 3);
         do_round(vp[0], vp[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
